// File: rtl/wb_burst_pkg.sv
// Shared types and constants for the Wishbone burst master.
// Holds the FSM state enum, CTI codes and length/CTI helpers.
package wb_burst_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WDATA,
    XFER,
    FIN
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // Zero-length commands run one beat; overlong ones are cut to max_len.
  function automatic logic [7:0] clamp_len(
    input logic [7:0] len,
    input logic [7:0] max_len
  );
    if (len == 8'd0)
      return 8'd1;
    if (len > max_len)
      return max_len;
    return len;
  endfunction

  // CTI for the beat about to be issued, given total length and
  // beats still outstanding (including this one).
  function automatic logic [2:0] beat_cti(
    input logic [7:0] len,
    input logic [7:0] rem
  );
    if (len == 8'd1)
      return CTI_CLASSIC;
    if (rem == 8'd1)
      return CTI_EOB;
    return CTI_INCR;
  endfunction

endpackage

// File: rtl/wb_burst_master_ack_timer.sv
// Ack timer for the Wishbone burst master: module wb_ack_timer.
// Ports: clk, rst_n, stb, ack in; expired out (combinational flag).
module wb_ack_timer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stb,
  input  logic ack,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYC + 1);

  logic [W-1:0] cnt;

  // cnt holds the number of completed strobe cycles without ack;
  // the cycle that would make it TIMEOUT_CYC is the expiring one.
  assign expired = stb && !ack
                && (cnt == W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (!stb || ack)
      cnt <= '0;
    else if (!expired)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone burst master: turns a command + write-data stream into
// incrementing Wishbone bursts and returns read beats.
// Ports: cmd_* command in, wr_* write data in, rd_* read data out,
// done/err completion, wb_* Wishbone master bus.
// Build option WB_TIMEOUT_EN adds an ack timeout (wb_ack_timer).
module wb_burst_master
  import wb_burst_pkg::*;
#(
  parameter int APP_AW      = 26,
  parameter int dw          = 32,
  parameter int MAX_LEN     = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              wb_clk,
  input  logic              wb_resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [APP_AW-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [dw-1:0]     wr_data,
  input  logic [dw/8-1:0]   wr_sel,
  output logic              rd_valid,
  output logic [dw-1:0]     rd_data,
  output logic              rd_last,
  output logic              done,
  output logic              err,
  output logic              wb_cyc,
  output logic              wb_stb,
  output logic              wb_we,
  output logic [APP_AW-1:0] wb_addr,
  output logic [dw-1:0]     wb_dati,
  output logic [dw/8-1:0]   wb_sel,
  output logic [2:0]        wb_cti,
  input  logic              wb_ack,
  input  logic [dw-1:0]     wb_dato
);

  localparam logic [7:0] MAXL = 8'(MAX_LEN);
  localparam logic [APP_AW-1:0] STEP = APP_AW'(dw / 8);

  state_t     state;
  logic       we_q;
  logic [7:0] len_q;
  logic [7:0] rem;
  logic [7:0] cmd_eff;

  assign cmd_eff = clamp_len(cmd_len, MAXL);

`ifdef WB_TIMEOUT_EN
  logic tmo;

  wb_ack_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (wb_clk),
    .rst_n  (wb_resetn),
    .stb    (wb_stb),
    .ack    (wb_ack),
    .expired(tmo)
  );
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge wb_clk or negedge wb_resetn) begin
    if (!wb_resetn) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      len_q     <= '0;
      rem       <= '0;
      cmd_ready <= 1'b0;
      wr_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_last   <= 1'b0;
      done      <= 1'b0;
      wb_cyc    <= 1'b0;
      wb_stb    <= 1'b0;
      wb_we     <= 1'b0;
      wb_addr   <= '0;
      wb_dati   <= '0;
      wb_sel    <= '0;
      wb_cti    <= '0;
`ifdef WB_TIMEOUT_EN
      err       <= 1'b0;
`endif
    end else begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      done     <= 1'b0;
`ifdef WB_TIMEOUT_EN
      err      <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            we_q      <= cmd_we;
            len_q     <= cmd_eff;
            rem       <= cmd_eff;
            wb_addr   <= cmd_addr;
            wb_cyc    <= 1'b1;
            wb_we     <= cmd_we;
            wb_cti    <= beat_cti(cmd_eff, cmd_eff);
            if (cmd_we) begin
              state    <= WDATA;
              wr_ready <= 1'b1;
            end else begin
              state  <= XFER;
              wb_stb <= 1'b1;
              wb_sel <= '1;
            end
          end
        end
        WDATA: begin
          if (wr_valid && wr_ready) begin
            wb_dati  <= wr_data;
            wb_sel   <= wr_sel;
            wr_ready <= 1'b0;
            wb_stb   <= 1'b1;
            state    <= XFER;
          end
        end
        XFER: begin
`ifdef WB_TIMEOUT_EN
          if (tmo) begin
            state  <= FIN;
            wb_cyc <= 1'b0;
            wb_stb <= 1'b0;
            wb_we  <= 1'b0;
            done   <= 1'b1;
            err    <= 1'b1;
          end else
`endif
          if (wb_ack && wb_stb) begin
            wb_addr <= wb_addr + STEP;
            rem     <= rem - 8'd1;
            if (!we_q) begin
              rd_valid <= 1'b1;
              rd_data  <= wb_dato;
              rd_last  <= (rem == 8'd1);
            end
            if (rem == 8'd1) begin
              state  <= FIN;
              wb_cyc <= 1'b0;
              wb_stb <= 1'b0;
              wb_we  <= 1'b0;
              done   <= 1'b1;
            end else begin
              wb_cti <= beat_cti(len_q, rem - 8'd1);
              if (we_q) begin
                wb_stb   <= 1'b0;
                wr_ready <= 1'b1;
                state    <= WDATA;
              end
            end
          end
        end
        FIN: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Scoreboard bench for wb_burst_master: random and directed commands
// against a per-command reference of expected bus/read/done events.
module tb_wb_burst_master;

  localparam int AW = 26;
  localparam int DW = 32;
  localparam int ML = 16;
  localparam int TC = 8;

  logic          wb_clk = 1'b0;
  logic          wb_resetn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic [3:0]    wr_sel;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          done;
  logic          err;
  logic          wb_cyc;
  logic          wb_stb;
  logic          wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_dati;
  logic [3:0]    wb_sel;
  logic [2:0]    wb_cti;
  logic          wb_ack;
  logic [DW-1:0] wb_dato;

  always #5 wb_clk = ~wb_clk;

  wb_burst_master #(
    .APP_AW(AW), .dw(DW), .MAX_LEN(ML), .TIMEOUT_CYC(TC)
  ) dut (
    .wb_clk(wb_clk), .wb_resetn(wb_resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_sel(wr_sel),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .err(err),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_addr(wb_addr), .wb_dati(wb_dati), .wb_sel(wb_sel),
    .wb_cti(wb_cti), .wb_ack(wb_ack), .wb_dato(wb_dato)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [2:0]    cti;
    logic [31:0]   data;
    logic [3:0]    sel;
  } beat_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } rd_t;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  s;
  } wr_t;

  beat_t bus_q[$];
  rd_t   rd_q[$];
  logic  err_q[$];
  wr_t   wr_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  int tick = 0;
  int t_acc, t_stb, t_ack, t_rd, t_done;
  int n_done = 0;
  int n_rd = 0;
  int n_ack = 0;
  int stb_run = 0;
  int stb_max = 0;
  int wr_rdy_rd = 0;
  logic stb_prev = 1'b0;
  logic [AW-1:0] last_addr;

  bit read_active = 0;
  bit no_ack = 0;
  bit fixed_mode = 0;
  int fixed_dly = 0;
  int slv_d = 0;
  bit spur_en = 1;
  bit wr_hold = 0;
  bit wr_toggle = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rdfun(logic [AW-1:0] a);
    return 32'h5EED0000 ^ ({6'd0, a} * 32'd2654435761);
  endfunction

  // Slave: acks after a delay, returns address-derived data,
  // and throws stray acks while the master holds cyc without stb.
  initial begin
    int w;
    w = 0;
    wb_ack = 1'b0;
    wb_dato = '0;
    forever begin
      @(posedge wb_clk);
      #1;
      if (!wb_resetn || wb_ack) begin
        wb_ack = 1'b0;
        w = 0;
      end else if (wb_cyc && wb_stb && !no_ack) begin
        if (w >= slv_d) begin
          wb_ack = 1'b1;
          wb_dato = rdfun(wb_addr);
          w = 0;
          slv_d = fixed_mode ? fixed_dly : $urandom_range(0, 4);
        end else begin
          w++;
        end
      end else if (wb_cyc && !wb_stb && spur_en) begin
        wb_ack = ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Write-data source; junk toggling only while nothing is queued.
  initial begin
    bit take;
    wr_valid = 1'b0;
    wr_data = '0;
    wr_sel = '0;
    forever begin
      @(negedge wb_clk);
      take = wr_valid && wr_ready && wb_resetn;
      @(posedge wb_clk);
      #1;
      if (take && wr_q.size() > 0)
        void'(wr_q.pop_front());
      if (wr_q.size() > 0) begin
        if (wr_hold || $urandom_range(0, 1) == 1) begin
          wr_valid = 1'b1;
          wr_data = wr_q[0].d;
          wr_sel = wr_q[0].s;
        end else begin
          wr_valid = 1'b0;
        end
      end else if (wr_toggle) begin
        wr_valid = ~wr_valid;
        wr_data = $urandom;
        wr_sel = 4'hF;
      end else begin
        wr_valid = 1'b0;
      end
    end
  end

  // Monitor: pops expected events whenever the DUT presents them.
  initial begin
    beat_t b;
    rd_t r;
    logic e;
    forever begin
      @(negedge wb_clk);
      tick++;
      if (wb_resetn) begin
        if (cmd_valid && cmd_ready)
          t_acc = tick;
        if (wb_stb && !stb_prev)
          t_stb = tick;
        stb_prev = wb_stb;
        stb_run = wb_stb ? stb_run + 1 : 0;
        if (stb_run > stb_max)
          stb_max = stb_run;
        if (wr_ready && read_active)
          wr_rdy_rd++;
        if (wb_stb && wb_ack) begin
          t_ack = tick;
          n_ack++;
          last_addr = wb_addr;
          chk("bus_expected", 64'(bus_q.size() != 0), 1);
          if (bus_q.size() != 0) begin
            b = bus_q.pop_front();
            chk("wb_addr", wb_addr, b.addr);
            chk("wb_we", wb_we, b.we);
            chk("wb_cti", wb_cti, b.cti);
            chk("wb_sel", wb_sel, b.sel);
            if (b.we)
              chk("wb_dati", wb_dati, b.data);
          end
        end
        if (rd_valid) begin
          t_rd = tick;
          n_rd++;
          chk("rd_expected", 64'(rd_q.size() != 0), 1);
          if (rd_q.size() != 0) begin
            r = rd_q.pop_front();
            chk("rd_data", rd_data, r.data);
            chk("rd_last", rd_last, r.last);
          end
        end
        if (done) begin
          t_done = tick;
          n_done++;
          chk("done_expected", 64'(err_q.size() != 0), 1);
          chk("cmd_ready_in_fin", cmd_ready, 0);
          chk("cyc_in_fin", wb_cyc, 0);
          if (err_q.size() != 0) begin
            e = err_q.pop_front();
            chk("err", err, e);
          end
        end
      end else begin
        stb_prev = 1'b0;
        stb_run = 0;
      end
    end
  end

  task automatic issue(bit we, logic [AW-1:0] a, logic [7:0] len,
                       bit seq, bit exp_err);
    int eff;
    int k;
    beat_t b;
    wr_t wd;
    rd_t r;
    eff = (len == 0) ? 1 : ((len > ML) ? ML : int'(len));
    if (!exp_err) begin
      for (int i = 0; i < eff; i++) begin
        b.addr = a + AW'(4 * i);
        b.we = we;
        b.cti = (eff == 1) ? 3'b000 :
                ((i == eff - 1) ? 3'b111 : 3'b010);
        if (we) begin
          wd.d = seq ? 32'hA0 + 32'(i) : $urandom;
          wd.s = seq ? 4'hF : 4'($urandom);
          wr_q.push_back(wd);
          b.data = wd.d;
          b.sel = wd.s;
        end else begin
          b.data = '0;
          b.sel = 4'hF;
          r.data = rdfun(b.addr);
          r.last = (i == eff - 1);
          rd_q.push_back(r);
        end
        bus_q.push_back(b);
      end
    end
    err_q.push_back(exp_err);
    read_active = !we;
    @(posedge wb_clk);
    #1;
    cmd_valid = 1'b1;
    cmd_we = we;
    cmd_addr = a;
    cmd_len = len;
    for (k = 0; k < 100; k++) begin
      @(negedge wb_clk);
      if (cmd_ready)
        break;
    end
    chk("cmd_accepted", cmd_ready, 1);
    @(posedge wb_clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 3000 && err_q.size() != 0; k++)
      @(negedge wb_clk);
    chk("done_seen", err_q.size(), 0);
    chk("bus_drained", bus_q.size(), 0);
    chk("rd_drained", rd_q.size(), 0);
    @(negedge wb_clk);
    read_active = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nrd0;
    int nd0;
    int k;
    wb_resetn = 1'b0;
    cmd_valid = 1'b0;
    cmd_we = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;
    #23;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_cyc", wb_cyc, 0);
    chk("rst_stb", wb_stb, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_addr", wb_addr, 0);
    @(negedge wb_clk);
    wb_resetn = 1'b1;
    @(posedge wb_clk);
    #1;
    chk("cmd_ready_after_rst", cmd_ready, 1);

    // Single read, fixed 3-cycle ack delay, latency checks.
    fixed_mode = 1;
    fixed_dly = 3;
    slv_d = 3;
    issue(0, 26'h100, 8'd1, 0, 0);
    wait_done();
    chk("lat_stb", t_stb - t_acc, 1);
    chk("lat_rd", t_rd - t_ack, 1);
    chk("lat_done", t_done - t_ack, 1);

    // Burst write, data held valid.
    fixed_mode = 0;
    wr_hold = 1;
    issue(1, 26'h200, 8'd4, 1, 0);
    wait_done();
    wr_hold = 0;

    // Burst read with wr_valid toggling.
    wr_toggle = 1;
    wr_rdy_rd = 0;
    nrd0 = n_rd;
    issue(0, 26'h300, 8'd4, 0, 0);
    wait_done();
    chk("wr_ready_in_read", wr_rdy_rd, 0);
    chk("rd_pulses", n_rd - nrd0, 4);
    wr_toggle = 0;

    // Address wrap.
    issue(0, 26'h3FFFFFC, 8'd2, 0, 0);
    wait_done();
    chk("wrap_addr", last_addr, 0);

    // Length boundaries: 0 runs one beat, 20 clamps to MAX_LEN.
    issue(1, 26'h040, 8'd0, 0, 0);
    wait_done();
    issue(0, 26'h080, 8'd20, 0, 0);
    wait_done();

    // Reset during beat 2 of a 4-beat read.
    fixed_mode = 1;
    fixed_dly = 2;
    slv_d = 2;
    nd0 = n_ack;
    issue(0, 26'h400, 8'd4, 0, 0);
    for (k = 0; k < 200; k++) begin
      @(negedge wb_clk);
      if (n_ack > nd0 && wb_stb && !wb_ack)
        break;
    end
    chk("reached_beat2", 64'(n_ack - nd0), 1);
    #2;
    wb_resetn = 1'b0;
    #1;
    chk("async_rst_cyc", wb_cyc, 0);
    chk("async_rst_stb", wb_stb, 0);
    bus_q.delete();
    rd_q.delete();
    err_q.delete();
    wr_q.delete();
    read_active = 0;
    nd0 = n_done;
    repeat (3) @(negedge wb_clk);
    wb_resetn = 1'b1;
    @(posedge wb_clk);
    #1;
    chk("cmd_ready_after_midrst", cmd_ready, 1);
    repeat (4) @(negedge wb_clk);
    chk("no_done_after_rst", n_done - nd0, 0);
    fixed_mode = 0;

`ifdef WB_TIMEOUT_EN
    // No ack: strobe held TC cycles, then done with err.
    no_ack = 1;
    stb_max = 0;
    nrd0 = n_rd;
    issue(0, 26'h500, 8'd2, 0, 1);
    wait_done();
    chk("tmo_stb_cycles", stb_max, TC);
    chk("tmo_no_rd", n_rd - nrd0, 0);
    no_ack = 0;
    issue(0, 26'h600, 8'd2, 0, 0);
    wait_done();
`endif

    // Randomized commands.
    for (int i = 0; i < 30; i++) begin
      wr_hold = ($urandom_range(0, 1) == 1);
      issue($urandom_range(0, 1) == 1,
            AW'($urandom) & 26'h3FFFFFC,
            8'($urandom_range(0, 20)), 0, 0);
      wait_done();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
